// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit path.
package uart_pkg;

    localparam int DBIT_DEF       = 8;
    localparam int FIFO_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        GAP
    } ctrl_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush, occupancy level and overflow pulse.
module uart_sync_fifo #(
    parameter int DBIT   = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DBIT-1:0]   wdata,
    input  logic              pop,
    output logic [DBIT-1:0]   rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == (ADDR_W+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            // Full is judged on the pre-cycle level, so a pop cannot make room.
            overflow <= push && full;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Transmit sequencer: FIFO-buffered bytes launched one frame at a time,
// with a programmable idle gap counted in baud ticks.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT       = DBIT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH),
    parameter int GAP_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_cfg,
    input  logic [GAP_W-1:0]  gap_cfg,
    input  logic [ADDR_W:0]   thr_cfg,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    output logic              wr_full,
    output logic              wr_overflow,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   fifo_level,
    output logic              thr_irq,
    output logic              ctrl_busy,
    input  logic              s_tick,
    input  logic              tx_busy,
    input  logic              tx_done_tick,
    output logic              tx_en,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_din
);

    ctrl_state_t      state;
    ctrl_state_t      state_next;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_next;
    logic             pop;
    logic [DBIT-1:0]  head;

    uart_sync_fifo #(
        .DBIT   (DBIT),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (wr_en),
        .wdata    (wr_data),
        .pop      (pop),
        .rdata    (head),
        .full     (wr_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .overflow (wr_overflow)
    );

    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                // A flush this cycle wins over launching the head entry.
                if (en_cfg && !fifo_empty && !tx_busy && !flush) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (tx_done_tick) begin
                    if (gap_cfg == '0) begin
                        state_next = IDLE;
                    end else begin
                        gap_next   = gap_cfg;
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (s_tick) begin
                    gap_next = gap_cnt - 1'b1;
                    if (gap_cnt == GAP_W'(1))
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            tx_din  <= '0;
            tx_en   <= 1'b0;
            thr_irq <= 1'b0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_next;
            if (pop)
                tx_din <= head;
            tx_en   <= en_cfg || (state != IDLE);
            thr_irq <= en_cfg && (fifo_level <= thr_cfg);
        end
    end

    assign tx_start  = (state == LAUNCH);
    assign ctrl_busy = !fifo_empty || (state != IDLE);

endmodule
